lab_input_debouncer: RTL and testbench



---
 rtl/lab_pkg.sv | 15 +
 rtl/deb_channel.sv | 118 +++++++++++
 rtl/lab_input_debouncer.sv | 40 ++++
 tb/tb_lab_input_debouncer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lab_pkg.sv
// Shared definitions for the lab input debouncer: FSM state encoding and
// debounce length constants (hardware default and simulation scale).
package lab_pkg;

   typedef enum logic [1:0] {
      ST_LO      = 2'd0,
      ST_WAIT_HI = 2'd1,
      ST_HI      = 2'd2,
      ST_WAIT_LO = 2'd3
   } deb_state_t;

   localparam int DEB_DEFAULT_CYCLES = 50000;
   localparam int DEB_SIM_CYCLES     = 4;

endpackage

// File: rtl/deb_channel.sv
// Single-bit synchroniser, debounce FSM, counter and rise/fall pulse logic.
// LAB_DEB_TOGGLE_EN turns sw_clean into a toggle on each debounced press.
module deb_channel
   import lab_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEB_DEFAULT_CYCLES,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_raw,
   output logic sw_clean,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam bit               SINGLE   = (DEBOUNCE_CYCLES == 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   sync_s;
   deb_state_t             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   clean_q, clean_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], sw_raw};
   assign sync_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         state_q <= ST_LO;
         cnt_q   <= '0;
         clean_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // The commit compare is made before the increment, so cnt never exceeds CNT_LAST.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_LO: begin
            if (sync_s) begin
               if (SINGLE) begin
                  state_d = ST_HI;
               end else begin
                  state_d = ST_WAIT_HI;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         ST_WAIT_HI: begin
            if (!sync_s) begin
               state_d = ST_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HI;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HI: begin
            if (!sync_s) begin
               if (SINGLE) begin
                  state_d = ST_LO;
               end else begin
                  state_d = ST_WAIT_LO;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         ST_WAIT_LO: begin
            if (sync_s) begin
               state_d = ST_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_LO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_LO;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      rise_d = (state_d == ST_HI) && ((state_q == ST_LO) || (state_q == ST_WAIT_HI));
      fall_d = (state_d == ST_LO) && ((state_q == ST_HI) || (state_q == ST_WAIT_LO));
`ifdef LAB_DEB_TOGGLE_EN
      clean_d = clean_q ^ rise_d;
`else
      clean_d = (state_d == ST_HI) || (state_d == ST_WAIT_LO);
`endif
   end

   assign sw_clean = clean_q;
   assign rise     = rise_q;
   assign fall     = fall_q;

endmodule

// File: rtl/lab_input_debouncer.sv
// N_CH independent debounce channels feeding the gate stage; any_change ORs all pulses.
// Build with LAB_DEB_TOGGLE_EN for latch-style (toggle) push-button behaviour.
module lab_input_debouncer
   import lab_pkg::*;
#(
   parameter int N_CH            = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEB_DEFAULT_CYCLES,
   parameter int CNT_W           = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] sw_raw,
   output logic [N_CH-1:0] sw_clean,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic            any_change
);

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         deb_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
         ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .sw_raw   (sw_raw[gi]),
            .sw_clean (sw_clean[gi]),
            .rise     (rise[gi]),
            .fall     (fall[gi])
         );
      end
   endgenerate

   // Pulses are registered, so this stays a single clean cycle wide.
   assign any_change = |{rise, fall};

endmodule

// File: tb/tb_lab_input_debouncer.sv
// Testbench for lab_input_debouncer: hand-derived vector table, corner sequences,
// and randomized stimulus against a sample-history reference model.
module tb_lab_input_debouncer;
   localparam int N = 2;
   localparam int S = 2;
   localparam int D = lab_pkg::DEB_SIM_CYCLES;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] sw_raw = '0;
   logic [N-1:0] sw_clean, rise, fall;
   logic         any_change;

   int vectors = 0;
   int miscompares = 0;
   int edge_cnt = 0;

   lab_input_debouncer #(
      .N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .sw_clean(sw_clean),
      .rise(rise), .fall(fall), .any_change(any_change)
   );

   always #5 clk = ~clk;

   // Reference model: raw input delayed S edges, then a level flips once the
   // last D visible samples all disagree with it.
   logic [N-1:0] m_dly [S];
   logic         hist [N][$];
   logic [N-1:0] m_level, m_tog, m_rise, m_fall;

   task automatic model_reset();
      for (int j = 0; j < S; j++) m_dly[j] = '0;
      for (int c = 0; c < N; c++) hist[c].delete();
      m_level = '0; m_tog = '0; m_rise = '0; m_fall = '0;
   endtask

   task automatic model_edge();
      logic [N-1:0] vis;
      logic         all_diff;
      vis = m_dly[S-1];
      m_rise = '0; m_fall = '0;
      for (int c = 0; c < N; c++) begin
         hist[c].push_back(vis[c]);
         if (hist[c].size() > D) void'(hist[c].pop_front());
         if (hist[c].size() == D) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++) if (hist[c][j] == m_level[c]) all_diff = 1'b0;
            if (all_diff) begin
               m_level[c] = ~m_level[c];
               if (m_level[c]) begin
                  m_rise[c] = 1'b1;
                  m_tog[c]  = ~m_tog[c];
               end else begin
                  m_fall[c] = 1'b1;
               end
            end
         end
      end
      for (int j = S-1; j > 0; j--) m_dly[j] = m_dly[j-1];
      m_dly[0] = sw_raw;
   endtask

   function automatic logic [N-1:0] exp_clean();
`ifdef LAB_DEB_TOGGLE_EN
      return m_tog;
`else
      return m_level;
`endif
   endfunction

   task automatic check(string name, logic [6:0] act, logic [6:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0t got{clean,rise,fall,any}=%b want=%b", name, $time, act, exp);
      end
   endtask

   task automatic check_int(string name, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
      end
   endtask

   task automatic tick(string name);
      @(posedge clk);
      edge_cnt++;
      model_edge();
      #1;
      check(name, {sw_clean, rise, fall, any_change},
            {exp_clean(), m_rise, m_fall, |{m_rise, m_fall}});
   endtask

   task automatic do_reset(int edges);
      #1 rst_n = 1'b0;
      model_reset();
      #1 check("rst_async", {sw_clean, rise, fall, any_change}, 7'b0);
      for (int i = 0; i < edges; i++) begin
         @(posedge clk);
         #1 check("rst_hold", {sw_clean, rise, fall, any_change}, 7'b0);
      end
      #2 rst_n = 1'b1;
      edge_cnt = 0;
   endtask

   typedef struct {
      logic [1:0] raw;
      logic [1:0] clean;
      logic [1:0] rise;
      logic [1:0] fall;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(logic [1:0] r, logic [1:0] c, logic [1:0] ri, logic [1:0] fa);
      vec_t v;
      v.raw = r; v.clean = c; v.rise = ri; v.fall = fa;
      tbl.push_back(v);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int n, at;
      logic b [5];
      model_reset();
      do_reset(3);

      // Row i is applied before edge i after reset release.
      for (int i = 1; i <= 10; i++) add(2'b00, 2'b00, 2'b00, 2'b00);
      for (int i = 11; i <= 15; i++) add(2'b01, 2'b00, 2'b00, 2'b00);
      add(2'b01, 2'b01, 2'b01, 2'b00);                                   // edge 16 = 11+S+D-1
      add(2'b01, 2'b01, 2'b00, 2'b00);
      for (int i = 18; i <= 20; i++) add(2'b11, 2'b01, 2'b00, 2'b00);   // 3-cycle glitch on ch1
      for (int i = 21; i <= 27; i++) add(2'b01, 2'b01, 2'b00, 2'b00);

      for (int i = 0; i < tbl.size(); i++) begin
         sw_raw = tbl[i].raw;
         @(posedge clk);
         edge_cnt++;
         model_edge();
         #1;
         $display("vec %0d raw=%b clean=%b rise=%b fall=%b any=%b", i + 1, sw_raw, sw_clean, rise, fall, any_change);
         check("table", {sw_clean, rise, fall, any_change},
               {tbl[i].clean, tbl[i].rise, tbl[i].fall, |{tbl[i].rise, tbl[i].fall}});
      end

      // Bounce on ch1 ending in a steady 1.
      b = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      n = 0; at = 0;
      for (int i = 0; i < 5; i++) begin
         sw_raw[1] = b[i];
         tick("bounce");
         if (i == 4) at = edge_cnt;
         if (rise[1]) n++;
      end
      begin
         int k, rise_at;
         k = at; rise_at = -1;
         for (int i = 0; i < 10; i++) begin
            tick("bounce_hold");
            if (rise[1]) begin n++; rise_at = edge_cnt; end
         end
         check_int("bounce_rise_count", n, 1);
         check_int("bounce_rise_edge", rise_at, k + S + D - 1);
         $display("seq bounce rises=%0d at_edge=%0d steady_from=%0d", n, rise_at, k);
      end

      sw_raw = 2'b00;
      for (int i = 0; i < 10; i++) tick("release");

      // Simultaneous rise on both channels.
      begin
         int n_both, n_any;
         n_both = 0; n_any = 0;
         sw_raw = 2'b11;
         for (int i = 0; i < 10; i++) begin
            tick("simul");
            if (rise == 2'b11) n_both++;
            if (any_change) n_any++;
         end
         check_int("simul_rise_both", n_both, 1);
         check_int("simul_any_change", n_any, 1);
         $display("seq simultaneous both_rise_cycles=%0d any_cycles=%0d", n_both, n_any);
      end

      sw_raw = 2'b00;
      for (int i = 0; i < 10; i++) tick("simul_release");

      // Reset in the middle of a count (counter at 2), input held through it.
      sw_raw = 2'b01;
      for (int i = 0; i < S + 2; i++) tick("precount");
      do_reset(2);
      at = -1;
      for (int i = 0; i < 12; i++) begin
         tick("post_reset");
         if (rise[0] && at < 0) at = edge_cnt;
      end
      check_int("reset_commit_edge", at, S + D);
      $display("seq reset_midcount commit_edge_after_release=%0d", at);

`ifdef LAB_DEB_TOGGLE_EN
      sw_raw = 2'b00;
      do_reset(2);
      for (int p = 0; p < 2; p++) begin
         sw_raw = 2'b01;
         for (int i = 0; i < 10; i++) tick("tog_press");
         check_int("tog_after_press", int'(sw_clean[0]), (p == 0) ? 1 : 0);
         sw_raw = 2'b00;
         for (int i = 0; i < 10; i++) tick("tog_release");
         check_int("tog_after_release", int'(sw_clean[0]), (p == 0) ? 1 : 0);
         $display("seq toggle press %0d clean=%b", p, sw_clean);
      end
`endif

      // Randomized input activity against the model.
      for (int blk = 0; blk < 8; blk++) begin
         for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 5) == 0) sw_raw[$urandom_range(0, N - 1)] ^= 1'b1;
            tick("random");
         end
         $display("random block %0d raw=%b clean=%b miscompares=%0d", blk, sw_raw, sw_clean, miscompares);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
